// File: rtl/key_pkg.sv
// Shared keypad constants and player state type.
// Used by key_player, div10_seq and the keypad code accumulator.
package key_pkg;

  localparam int KEY_MIN = 1;
  localparam int KEY_MAX = 6;
  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_PRESS   = 3'd2,
    ST_GAP     = 3'd3,
    ST_FINISH  = 3'd4
  } kp_state_t;

  // Only keys 1..6 exist on the pad.
  function automatic logic digit_ok(
    input logic [DIGIT_W-1:0] d
  );
    return (d >= DIGIT_W'(KEY_MIN)) &&
           (d <= DIGIT_W'(KEY_MAX));
  endfunction

endpackage

// File: rtl/div10_seq.sv
// Sequential restoring divide-by-10, fixed 33 cycles (load + 32 shifts).
// Ports: hwclk, reset_n, load, dividend -> quotient, remainder, ready.
module div10_seq
  import key_pkg::*;
(
  input  logic               hwclk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [CODE_W-1:0]  dividend,
  output logic [CODE_W-1:0]  quotient,
  output logic [DIGIT_W-1:0] remainder,
  output logic               ready
);

  logic [5:0]       cnt;
  logic [DIGIT_W:0] trial;

  // Dividend bits shift out of the top of quotient while
  // quotient bits shift in at the bottom.
  assign trial = {remainder, quotient[CODE_W-1]};

  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      ready     <= 1'b0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      cnt       <= 6'd32;
      ready     <= 1'b0;
    end else if (cnt != 6'd0) begin
      cnt   <= cnt - 6'd1;
      ready <= (cnt == 6'd1);
      if (trial >= 5'd10) begin
        remainder <= DIGIT_W'(trial - 5'd10);
        quotient  <= {quotient[CODE_W-2:0], 1'b1};
      end else begin
        remainder <= trial[DIGIT_W-1:0];
        quotient  <= {quotient[CODE_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/key_player.sv
// Replays a 32-bit code as keypad presses, MS decimal digit first.
// Ports: hwclk, reset_n, start, value -> key, button_pressed, busy,
// done, error; kl_enable when KEY_PLAYER_ENABLE_OUT_EN is defined.
module key_player
  import key_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_DIGITS   = 10
) (
  input  logic              hwclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CODE_W-1:0] value,
  output logic [7:0]        key,
  output logic              button_pressed,
  output logic              busy,
  output logic              done,
`ifdef KEY_PLAYER_ENABLE_OUT_EN
  output logic              kl_enable,
`endif
  output logic              error
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMAX  = (PRESS_CYCLES > GAP_CYCLES) ?
                         PRESS_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  kp_state_t          state;
  logic [DIGIT_W-1:0] digits [MAX_DIGITS];
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   idx;
  logic [TW-1:0]      tmr;

  logic               accept;
  logic               div_load;
  logic [CODE_W-1:0]  div_in;
  logic [CODE_W-1:0]  quo;
  logic [DIGIT_W-1:0] rem;
  logic               div_rdy;
  logic               full;

  assign accept = (state == ST_IDLE) && start;

  // The start cycle doubles as the first divider load; later loads
  // chain on ready so each division costs exactly 33 cycles.
  assign div_load = (accept && (value != '0)) ||
                    ((state == ST_CONVERT) && div_rdy);
  assign div_in   = (state == ST_IDLE) ? value : quo;

  // Guard against a buffer smaller than the number of digits.
  assign full = (count == CNT_W'(MAX_DIGITS - 1)) &&
                (quo != '0);

  div10_seq u_div (
    .hwclk     (hwclk),
    .reset_n   (reset_n),
    .load      (div_load),
    .dividend  (div_in),
    .quotient  (quo),
    .remainder (rem),
    .ready     (div_rdy)
  );

  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
      idx   <= '0;
      tmr   <= '0;
      error <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++)
        digits[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            error <= 1'b0;
            count <= '0;
            state <= (value == '0) ? ST_FINISH
                                   : ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (div_rdy) begin
            if (!digit_ok(rem) || full) begin
              error <= 1'b1;
              state <= ST_FINISH;
            end else begin
              digits[count] <= rem;
              count <= count + CNT_W'(1);
              if (quo == '0) begin
                idx   <= count;
                tmr   <= '0;
                state <= ST_PRESS;
              end
            end
          end
        end
        ST_PRESS: begin
          if (tmr == TW'(PRESS_CYCLES - 1)) begin
            tmr   <= '0;
            state <= ST_GAP;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_GAP: begin
          if (tmr == TW'(GAP_CYCLES - 1)) begin
            tmr <= '0;
            if (idx == '0) begin
              state <= ST_FINISH;
            end else begin
              idx   <= idx - CNT_W'(1);
              state <= ST_PRESS;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign button_pressed = (state == ST_PRESS);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_FINISH);
  assign key = ((state == ST_PRESS) || (state == ST_GAP)) ?
               8'(digits[idx]) : 8'd0;

`ifdef KEY_PLAYER_ENABLE_OUT_EN
  logic en_q;
  logic last_div;

  // High in the final CONVERT cycle so enable leads the first press.
  assign last_div = (state == ST_CONVERT) && div_rdy &&
                    digit_ok(rem) && !full && (quo == '0);

  always_ff @(posedge hwclk) begin
    if (!reset_n)
      en_q <= 1'b0;
    else if (accept)
      en_q <= 1'b0;
    else if (last_div)
      en_q <= 1'b1;
  end

  assign kl_enable = en_q | last_div;
`endif

endmodule

// File: tb/tb_key_player.sv
// Directed self-checking bench for key_player.
// Models the accumulator as acc = 10*acc + key on each press edge.
module tb_key_player;

  logic        hwclk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] value;
  logic [7:0]  key;
  logic        button_pressed;
  logic        busy;
  logic        done;
  logic        error;

  int passed = 0;
  int total  = 0;

  always #5 hwclk = ~hwclk;

  key_player dut (
    .hwclk          (hwclk),
    .reset_n        (reset_n),
    .start          (start),
    .value          (value),
    .key            (key),
    .button_pressed (button_pressed),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  typedef struct {
    logic [31:0] v;
    int acc;
    int np;
    int first;
    int done_c;
    int err;
  } vec_t;

  vec_t tbl[9];
  int   prev_err;

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
  endtask

  // Cycle k is sampled 1 time unit after the k-th edge following
  // the cycle in which start is driven high.
  task automatic run(input logic [31:0] v, input int e_acc,
                     input int e_np, input int e_first,
                     input int e_done, input int e_err,
                     input int inj);
    int acc = 0;
    int np = 0;
    int first = -1;
    int dc = -1;
    int ndone = 0;
    int hi = 0;
    int lo = 0;
    int shape_ok = 1;
    int busy_ok = 1;
    int busy_aft = -1;
    int err_aft = -1;
    int key_aft = -1;
    logic prev = 1'b0;
    logic [7:0] lkey = 8'd0;
    @(posedge hwclk); #1;
    chk("error_held", int'(error), prev_err);
    start = 1'b1;
    value = v;
    for (int k = 1; k <= 600; k++) begin
      @(posedge hwclk); #1;
      if (k == 1) begin
        start = 1'b0;
        value = $urandom;
      end
      if (inj != 0 && k == inj) begin
        start = 1'b1;
        value = 32'd5;
      end
      if (inj != 0 && k == inj + 1)
        start = 1'b0;
      if (button_pressed) begin
        if (!prev) begin
          np++;
          acc = acc * 10 + int'(key);
          if (first < 0) first = k;
          if (np > 1 && lo != 4) shape_ok = 0;
          hi = 1;
          lkey = key;
        end else begin
          hi++;
          if (key != lkey) shape_ok = 0;
        end
      end else begin
        if (prev) begin
          if (hi != 4) shape_ok = 0;
          lo = 1;
        end else begin
          lo++;
        end
        if (dc < 0 && np > 0 && lo <= 4 && key != lkey)
          shape_ok = 0;
      end
      prev = button_pressed;
      if (done) begin
        ndone++;
        if (dc < 0) dc = k;
      end
      if (dc < 0 && !busy) busy_ok = 0;
      if (dc >= 0 && k == dc + 1) begin
        busy_aft = int'(busy);
        err_aft  = int'(error);
        key_aft  = int'(key);
        break;
      end
    end
    chk("done_cycle", dc, e_done);
    chk("done_count", ndone, 1);
    chk("presses", np, e_np);
    chk("acc_value", acc, e_acc);
    chk("first_press", first, e_first);
    chk("press_shape", shape_ok, 1);
    chk("busy_cover", busy_ok, 1);
    chk("busy_after", busy_aft, 0);
    chk("key_after", key_aft, 0);
    chk("error", err_aft, e_err);
    prev_err = e_err;
  endtask

  initial begin
    tbl[0] = '{32'd123,        123,       3, 100, 124, 0};
    tbl[1] = '{32'd0,          0,         0, -1,  1,   0};
    tbl[2] = '{32'd170,        0,         0, -1,  34,  1};
    tbl[3] = '{32'd16,         16,        2, 67,  83,  0};
    tbl[4] = '{32'd666666666,  666666666, 9, 298, 370, 0};
    tbl[5] = '{32'd7,          0,         0, -1,  34,  1};
    tbl[6] = '{32'd654321,     654321,    6, 199, 247, 0};
    tbl[7] = '{32'd10,         0,         0, -1,  34,  1};
    tbl[8] = '{32'hFFFFFFFF,   0,         0, -1,  67,  1};

    reset_n  = 1'b0;
    start    = 1'b0;
    value    = 32'd0;
    prev_err = 0;
    repeat (3) @(posedge hwclk);
    #1;
    chk("rst_key", int'(key), 0);
    chk("rst_bp", int'(button_pressed), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run(tbl[i].v, tbl[i].acc, tbl[i].np, tbl[i].first,
          tbl[i].done_c, tbl[i].err, 0);

    // Second start during a press must be ignored.
    run(32'd123, 123, 3, 100, 124, 0, 109);

    // Reset in the middle of the second press of 456.
    begin
      int nd = 0;
      int nbp = 0;
      @(posedge hwclk); #1;
      start = 1'b1;
      value = 32'd456;
      for (int k = 1; k <= 109; k++) begin
        @(posedge hwclk); #1;
        if (k == 1) start = 1'b0;
      end
      chk("mid_bp_before", int'(button_pressed), 1);
      reset_n = 1'b0;
      @(posedge hwclk); #1;
      chk("rst_mid_bp", int'(button_pressed), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      reset_n = 1'b1;
      for (int k = 0; k < 150; k++) begin
        @(posedge hwclk); #1;
        if (done) nd++;
        if (button_pressed) nbp++;
      end
      chk("post_rst_done", nd, 0);
      chk("post_rst_bp", nbp, 0);
      prev_err = 0;
    end
    run(32'd456, 456, 3, 100, 124, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_player.md
Name: key_player

Overview:
- Transmit-side counterpart of the keypad code accumulator.
- Takes a 32-bit code value and replays it as a sequence of keypad presses (key code plus press strobe), most-significant decimal digit first.
- The accumulator rebuilds the value as 10*current + key, so the replay lets it reconstruct the code.
- Used for self-test and for auto-entry of stored codes. Sits between the code store and the accumulator's key/button_pressed/enable inputs.

Parameters:
- PRESS_CYCLES, 4: cycles button_pressed is held high per digit (min 1).
- GAP_CYCLES, 4: cycles button_pressed is held low after each press (min 1).
- MAX_DIGITS, 10: depth of the digit buffer; 10 covers every 32-bit value.

Ports:
- hwclk  in  1  system clock (12 MHz)
- reset_n  in  1  synchronous active-low reset
- start  in  1  begin replay of value; sampled only in IDLE
- value  in  32  code to replay; latched on accepted start
- key  out  8  current key code, zero-extended digit 1..6
- button_pressed  out  1  press strobe
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of session
- error  out  1  set when value contains a digit 0 or 7..9; held until next accepted start

Behaviour:
- Clock and reset:
  - One clock, hwclk.
  - Reset is synchronous, active-low on reset_n, evaluated at posedge hwclk.
  - Reset values: key=0, button_pressed=0, busy=0, done=0, error=0; state=IDLE; buffer, counters and digit count cleared.
  - Reset mid-session aborts immediately: button_pressed is 0 from the first post-reset cycle, and no done pulse is produced.
- States: IDLE, CONVERT, PRESS, GAP, FINISH.
- IDLE:
  - start=1 latches value, clears error and digit count, and asserts busy on the next cycle.
  - If value==0: go to FINISH. No presses are emitted, since an accumulator that starts at 0 needs none.
  - Otherwise: go to CONVERT.
- CONVERT:
  - Repeated divide-by-10 via the sequential divider: remainder becomes the next digit (LS first, pushed into the buffer), quotient becomes the new dividend.
  - Each division takes exactly 33 cycles (1 load + 32 shift-subtract).
  - Any remainder of 0 or >6 sets error and goes to FINISH with no presses.
  - When the quotient reaches 0, go to PRESS with index = count-1 (MS digit first).
- PRESS:
  - key = buffer[index], button_pressed=1 for PRESS_CYCLES cycles, then go to GAP.
  - key is stable from the first PRESS cycle through the last GAP cycle.
- GAP:
  - button_pressed=0 for GAP_CYCLES cycles.
  - If index==0, go to FINISH; else decrement index and return to PRESS.
- FINISH: done=1 for one cycle, busy=0 and key=0 on the next cycle, then return to IDLE.
- start while busy is ignored; value changes while busy are ignored.
- Every press is a clean rising edge preceded by at least GAP_CYCLES low cycles (minimum 1 between sessions), so the accumulator's edge detector counts each digit exactly once.
- Arithmetic:
  - Divider dividend is 32-bit unsigned; remainder is 4-bit.
  - Digit count is a clog2(MAX_DIGITS+1)-bit counter and never exceeds 10.

Optional Feature:
- KEY_PLAYER_ENABLE_OUT_EN defined: adds output kl_enable (1 bit, reset 0), which drives the accumulator's enable.
  - kl_enable=0 in IDLE and CONVERT, which clears the accumulator.
  - It rises one cycle before the first PRESS and stays 1 through FINISH and IDLE until the next accepted start.
  - For value==0 or error, kl_enable stays 0.
- Undefined: port absent. The integrator drives the accumulator's enable independently; all other behaviour is identical.

Decomposition:
- Shared package key_pkg:
  - state enum for the player;
  - KEY_MIN=1, KEY_MAX=6, DIGIT_W=4, CODE_W=32 constants, reused by the accumulator.
- One sub-module, div10_seq: sequential 32-bit restoring divide by 10.
  - Ports: load, dividend, quotient, remainder, ready.
  - Fixed 33-cycle latency.

Test Plan:
- start with value=123 → after 3×33 CONVERT cycles, presses key=1,2,3, each 4 high / 4 low; done pulses once; error=0; a connected accumulator reads 123.
- value=0 → no presses; done within 3 cycles of start; error=0.
- value=170 → error=1, zero presses, done pulses; next start with value=16 clears error and plays 1,6.
- value=666666666 → nine presses all key=6; accumulator reads 666666666; busy covers the whole session.
- start pulsed again mid-PRESS with value=5 → ignored; original sequence completes unchanged.
- reset_n=0 during the second PRESS of value=456 → button_pressed=0 next cycle; busy=0, done never pulses; a subsequent start plays cleanly.
